alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares one combinational ALU between two requesters, for example the EX stage and a branch/exception helper. It accepts one operation at a time through a valid/ready handshake and grants the ports round-robin. It drives the ALU from registered operands, captures the result, and returns it on the matching response port. It sits between the requesters and the ALU instance in the pipelined core.

---
 rtl/alu_share_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_share_arb.sv | 128 ++++++++++++
 tb/tb_alu_share_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter.
//   - FSM state encoding for the sequencer
//   - default datapath widths
//   - ALU function codes, used by benches only; the arbiter itself
//     passes function codes through without decoding them
package alu_share_arb_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SLT = 6'b110101;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant.
//   req  : request vector, bit N = requester N valid
//   last : requester granted most recently; the other one wins a tie
//   gnt  : one-hot grant, or all zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters.
// One operation is in flight at a time: IDLE accepts a request (round-robin
// between ports), EXEC drives the ALU from registered operands for one cycle
// and captures its result, and RESP holds that result on the owner's response
// port until it is taken.
//   req0_* / req1_* : valid/ready request ports with fun, sign, a, b
//   rsp0_* / rsp1_* : valid/ready response ports with z and zero
//   alu_*           : operands to and results from the shared ALU
//   op_count        : completed operations, wrapping at 16 bits
module alu_share_arb #(
  parameter int unsigned DW = 32,
  parameter int unsigned FW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [FW-1:0] req0_fun,
  input  logic          req0_sign,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [FW-1:0] req1_fun,
  input  logic          req1_sign,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_z,
  output logic          rsp0_zero,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_z,
  output logic          rsp1_zero,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [FW-1:0] alu_fun,
  output logic          alu_sign,
  input  logic [DW-1:0] alu_z,
  input  logic          alu_zero,
  output logic [15:0]   op_count
);

  import alu_share_arb_pkg::*;

  state_t        state_q, state_d;
  logic          last_q;
  logic          owner_q;
  logic [FW-1:0] fun_q;
  logic          sign_q;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] z_q;
  logic          zero_q;
  logic [15:0]   op_count_q;

  logic [1:0]    gnt;
  logic          idle;
  logic          accept;
  logic          rsp_fire;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign idle       = (state_q == IDLE) && !reset;
  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];
  assign accept     = idle && (gnt != 2'b00);
  assign rsp_fire   = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      fun_q      <= '0;
      sign_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      z_q        <= '0;
      zero_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt[1];
        last_q  <= gnt[1];
        fun_q   <= gnt[1] ? req1_fun  : req0_fun;
        sign_q  <= gnt[1] ? req1_sign : req0_sign;
        a_q     <= gnt[1] ? req1_a    : req0_a;
        b_q     <= gnt[1] ? req1_b    : req0_b;
      end
      if (state_q == EXEC) begin
        z_q    <= alu_z;
        zero_q <= alu_zero;
      end
      if (rsp_fire) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_fun  = fun_q;
  assign alu_sign = sign_q;

  // Both response ports see the same result registers; only valid is steered.
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp0_z     = z_q;
  assign rsp1_z     = z_q;
  assign rsp0_zero  = zero_q;
  assign rsp1_zero  = zero_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req0_sign;
  logic [5:0]  req0_fun;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sign;
  logic [5:0]  req1_fun;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_zero;
  logic [31:0] rsp0_z;
  logic        rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp1_z;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [5:0]  alu_fun;
  logic        alu_sign, alu_zero;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        port;
    logic [31:0] z;
    logic        zero;
  } exp_t;
  exp_t sb[$];

  logic [5:0] funs [6] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SLT};

  alu_share_arb #(.DW(32), .FW(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
    .req0_sign(req0_sign), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
    .req1_sign(req1_sign), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .alu_z(alu_z), .alu_zero(alu_zero), .op_count(op_count)
  );

  // Reference ALU of the datapath: SLL shifts b by a, zero means a != b.
  function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLL: return b << a[4:0];
      ALU_SLT: return s ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  assign alu_z    = alu_ref(alu_fun, alu_sign, alu_a, alu_b);
  assign alu_zero = (alu_a != alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (req0_valid && req0_ready)
        sb.push_back('{1'b0, alu_ref(req0_fun, req0_sign, req0_a, req0_b), req0_a != req0_b});
      if (req1_valid && req1_ready)
        sb.push_back('{1'b1, alu_ref(req1_fun, req1_sign, req1_a, req1_b), req1_a != req1_b});
      if (req0_ready || req1_ready || rsp0_valid || rsp1_valid) begin
        vectors++;
        if ((req0_ready && req1_ready) || (rsp0_valid && rsp1_valid)) begin
          miscompares++;
          $display("FAIL exclusive: ready=%b%b rsp_valid=%b%b required at most one each",
                   req1_ready, req0_ready, rsp1_valid, rsp0_valid);
        end
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: response on port %0d z=%h with nothing outstanding",
                   rsp1_valid, rsp1_valid ? rsp1_z : rsp0_z);
        end else begin
          e = sb.pop_front();
          if ({rsp1_valid, rsp1_valid ? rsp1_z : rsp0_z, rsp1_valid ? rsp1_zero : rsp0_zero}
              !== {e.port, e.z, e.zero}) begin
            miscompares++;
            $display("FAIL sb_result: got port=%0d z=%h zero=%b expected port=%0d z=%h zero=%b",
                     rsp1_valid, rsp1_valid ? rsp1_z : rsp0_z,
                     rsp1_valid ? rsp1_zero : rsp0_zero, e.port, e.z, e.zero);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand(input logic p);
    logic [5:0]  f = funs[$urandom_range(0, 5)];
    logic        s = 1'($urandom_range(0, 1));
    logic [31:0] a = $urandom;
    logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (p) begin req1_fun = f; req1_sign = s; req1_a = a; req1_b = b; end
    else   begin req0_fun = f; req0_sign = s; req0_a = a; req0_b = b; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_fun = ALU_ADD; req0_sign = 1'b0; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_fun = ALU_SUB; req1_sign = 1'b0; req1_a = 32'd3; req1_b = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, op_count, alu_a, alu_b, alu_fun, alu_sign,
         rsp0_z, rsp0_zero} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b%b rsp_valid=%b%b op_count=%h alu_a=%h alu_b=%h fun=%h sign=%b z=%h zero=%b, all required 0",
               req1_ready, req0_ready, rsp1_valid, rsp0_valid, op_count, alu_a, alu_b, alu_fun,
               alu_sign, rsp0_z, rsp0_zero);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_fun = ALU_ADD; req0_sign = 1'b0; req0_a = 32'd5; req0_b = 32'd7;
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_accept: ready1/0=%b%b required 01", req1_ready, req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({alu_a, alu_b, alu_fun, rsp0_valid} !== {32'd5, 32'd7, ALU_ADD, 1'b0}) begin
      miscompares++;
      $display("FAIL single_exec: alu_a=%h alu_b=%h fun=%h rsp0_valid=%b required 5 7 00 0",
               alu_a, alu_b, alu_fun, rsp0_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({rsp0_valid, rsp0_z, rsp0_zero, rsp1_valid} !== {1'b1, 32'd12, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_resp: rsp0_valid=%b z=%h zero=%b rsp1_valid=%b required 1 0000000c 1 0",
               rsp0_valid, rsp0_z, rsp0_zero, rsp1_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({op_count, rsp0_valid} !== {16'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_count: op_count=%0d rsp0_valid=%b required 1 0", op_count, rsp0_valid);
    end
    tick();
  endtask

  task automatic test_tie();
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_fun = ALU_SUB; req0_sign = 1'b0; req0_a = 32'd9;    req0_b = 32'd4;
    req1_valid = 1'b1; req1_fun = ALU_OR;  req1_sign = 1'b0; req1_a = 32'hF0;   req1_b = 32'h0F;
    @(negedge clk);
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_first: ready1/0=%b%b required 01", req1_ready, req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL tie_busy: ready1/0=%b%b required 00 in EXEC", req1_ready, req0_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({rsp0_valid, rsp0_z, rsp1_valid, req1_ready} !== {1'b1, 32'd5, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_rsp0: rsp0_valid=%b z=%h rsp1_valid=%b req1_ready=%b required 1 00000005 0 0",
               rsp0_valid, rsp0_z, rsp1_valid, req1_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_second: ready1/0=%b%b at N+3 required 10", req1_ready, req0_ready);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    vectors++;
    if ({rsp1_valid, rsp1_z, rsp1_zero, rsp0_valid} !== {1'b1, 32'hFF, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_rsp1: rsp1_valid=%b z=%h zero=%b rsp0_valid=%b required 1 000000ff 1 0",
               rsp1_valid, rsp1_z, rsp1_zero, rsp0_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd2) begin
      miscompares++;
      $display("FAIL tie_count: op_count=%0d required 2", op_count);
    end
    tick();
  endtask

  task automatic test_alternate();
    int   grants = 0;
    int   budget = 0;
    logic exp_port = 1'b0;
    logic got;
    reset = 1'b1; tick(); reset = 1'b0;
    set_rand(1'b0); set_rand(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    while (grants < 6 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (req0_ready || req1_ready) begin
        got = req1_ready;
        vectors++;
        if (got !== exp_port) begin
          miscompares++;
          $display("FAIL alt_grant%0d: granted port %0d required %0d", grants, got, exp_port);
        end
        exp_port = ~exp_port;
        grants++;
        tick();
        if (grants == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        else set_rand(got);
      end else begin
        tick();
      end
    end
    vectors++;
    if (grants != 6) begin
      miscompares++;
      $display("FAIL alt_timeout: %0d grants within budget, required 6", grants);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    repeat (4) tick();
    @(negedge clk);
    vectors++;
    if ({op_count, rsp0_valid, rsp1_valid} !== {16'd6, 2'b00}) begin
      miscompares++;
      $display("FAIL alt_count: op_count=%0d rsp_valid=%b%b required 6 00", op_count, rsp1_valid, rsp0_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_fun = ALU_SLL; req1_sign = 1'b0; req1_a = 32'd4; req1_b = 32'd1;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: req1_ready=%b required 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    while (!rsp1_valid && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (rsp1_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_timeout: rsp1_valid=%b after %0d cycles, required 1", rsp1_valid, n);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      req0_valid = 1'b1; req0_fun = ALU_ADD; req0_sign = 1'b0; req0_a = 32'd1; req0_b = 32'd2;
      @(negedge clk);
      vectors++;
      if ({rsp1_valid, rsp1_z, rsp1_zero, req0_ready, req1_ready} !== {1'b1, 32'd16, 1'b1, 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: rsp1_valid=%b z=%h zero=%b ready1/0=%b%b required 1 00000010 1 00",
                 i, rsp1_valid, rsp1_z, rsp1_zero, req1_ready, req0_ready);
      end
    end
    tick();
    rsp1_ready = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp1_valid, rsp1_z} !== {1'b1, 32'd16}) begin
      miscompares++;
      $display("FAIL bp_release: rsp1_valid=%b z=%h required 1 00000010", rsp1_valid, rsp1_z);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({rsp1_valid, op_count} !== {1'b0, 16'd1}) begin
      miscompares++;
      $display("FAIL bp_done: rsp1_valid=%b op_count=%0d required 0 1", rsp1_valid, op_count);
    end
    tick();
  endtask

  task automatic test_reset_exec();
    int n = 0;
    req0_valid = 1'b1; req0_fun = ALU_SLT; req0_sign = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_accept: req0_ready=%b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({alu_fun, alu_sign, alu_a} !== {ALU_SLT, 1'b1, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL rx_exec: fun=%h sign=%b alu_a=%h required 35 1 ffffffff", alu_fun, alu_sign, alu_a);
    end
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_fun = ALU_ADD; req0_sign = 1'b0; req0_a = 32'd3; req0_b = 32'd3;
    req1_valid = 1'b1; req1_fun = ALU_SUB; req1_sign = 1'b0; req1_a = 32'd8; req1_b = 32'd2;
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, op_count, alu_a, alu_fun}
        !== {1'b1, 1'b0, 2'b00, 16'd0, 32'd0, 6'd0}) begin
      miscompares++;
      $display("FAIL rx_after: ready0/1=%b%b rsp_valid=%b%b op_count=%0d alu_a=%h fun=%h required 10 00 0 0 0",
               req0_ready, req1_ready, rsp1_valid, rsp0_valid, op_count, alu_a, alu_fun);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    while (!req1_ready && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_loser: req1_ready=%b after %0d cycles, required 1", req1_ready, n);
    end
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    vectors++;
    if (op_count !== 16'd2) begin
      miscompares++;
      $display("FAIL rx_count: op_count=%0d required 2", op_count);
    end
    tick();
  endtask

  task automatic test_rollover();
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    @(negedge clk);
    vectors++;
    if (op_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL roll_preload: op_count=%h required ffff", op_count);
    end
    tick();
    req0_valid = 1'b1; req0_fun = ALU_AND; req0_sign = 1'b0;
    req0_a = 32'hFF00_FF00; req0_b = 32'h0FF0_0FF0;
    @(negedge clk);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL roll_accept: req0_ready=%b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if (op_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL roll_wrap: op_count=%h required 0000", op_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_backpressure();
    test_reset_exec();
    test_rollover();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
